fp_mul_status_monitor: RTL and testbench

Parametrised, synthesizable run-time monitor for the floating-point multiplier's status/result interface. It sits beside the multiplier in the verification bench and, optionally, on silicon. It re-times operands through a LATENCY-deep delay line and checks every valid result against its status flags and against its own operands. It also keeps per-check saturating failure counters, sticky flags and a first-failure record. Compared with the earlier assertion-only checker, it adds generic exponent/mantissa width, configurable pipeline latency, valid qualification, a protocol check and persistent error bookkeeping.

---
 rtl/fp_mul_status_monitor.sv | 215 +++++++++++++++++++++
 tb/tb_fp_mul_status_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_status_monitor.sv
// Purpose: run-time checker for the FP multiplier status/result port: retimes operand exponents, checks every result, keeps error bookkeeping.
// Latency: operands retimed LATENCY cycles to meet pz/pstatus; failure outputs are registered and update on the evaluation edge.
// Backpressure: none; accepts operands and results every cycle and never stalls the multiplier.
module fp_mul_status_monitor #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic                   pclk,
    input  logic                   prst_n,      // active-high synchronous reset despite the name
    input  logic                   in_valid,
    input  logic [EXP_W+MAN_W:0]   pa,
    input  logic [EXP_W+MAN_W:0]   pb,
    input  logic                   out_valid,
    input  logic [EXP_W+MAN_W:0]   pz,
    input  logic [7:0]             pstatus,
    input  logic                   clear,
    input  logic [7:0]             chk_mask,
    output logic [7:0]             fail_pulse,
    output logic [7:0]             sticky,
    output logic [8*CNT_W-1:0]     fail_cnt,
    output logic                   first_valid,
    output logic [2:0]             first_id,
    output logic [31:0]            first_time,
    output logic                   irq
);

    localparam int W = 1 + EXP_W + MAN_W;

    // Exponent/magnitude constants used by the status checks.
    localparam logic [EXP_W-1:0]       E_ZERO = '0;
    localparam logic [EXP_W-1:0]       E_ONES = '1;
    localparam logic [EXP_W-1:0]       E_MAXN = E_ONES - EXP_W'(1);
    localparam logic [W-2:0]           MAXN   = {E_MAXN, {MAN_W{1'b1}}};
    localparam logic [W-2:0]           MINN   = {EXP_W'(1), {MAN_W{1'b0}}};
    localparam logic [CNT_W-1:0]       CNT_MAX = '1;

    // ------------------------------------------------------------------
    // Operand delay line. Only the exponents of a/b feed any check, so
    // only those travel down the line; sign and mantissa are dropped here.
    // ------------------------------------------------------------------
    logic [LATENCY-1:0]  dv_q;
    logic [EXP_W-1:0]    ea_q [LATENCY];
    logic [EXP_W-1:0]    eb_q [LATENCY];

    // Valid bits of the delay line; reset flushes everything in flight.
    always_ff @(posedge pclk) begin
        if (prst_n) begin
            dv_q <= '0;
        end else begin
            dv_q[0] <= in_valid;
            for (int i = 1; i < LATENCY; i++) begin
                dv_q[i] <= dv_q[i-1];
            end
        end
    end

    // Exponent payload of the delay line; qualified by dv_q so no reset needed.
    always_ff @(posedge pclk) begin
        ea_q[0] <= pa[W-2:MAN_W];
        eb_q[0] <= pb[W-2:MAN_W];
        for (int i = 1; i < LATENCY; i++) begin
            ea_q[i] <= ea_q[i-1];
            eb_q[i] <= eb_q[i-1];
        end
    end

    logic             dv;
    logic [EXP_W-1:0] e_a;
    logic [EXP_W-1:0] e_b;
    logic [EXP_W-1:0] e_z;

    assign dv  = dv_q[LATENCY-1];
    assign e_a = ea_q[LATENCY-1];
    assign e_b = eb_q[LATENCY-1];
    assign e_z = pz[W-2:MAN_W];

    // Bits that no check looks at: signs, operand mantissas, pstatus[5].
    logic unused_bits;
    assign unused_bits = ^{pa[W-1], pa[MAN_W-1:0], pb[W-1], pb[MAN_W-1:0], pz[W-1], pstatus[5]};

    // ------------------------------------------------------------------
    // Check evaluation
    // ------------------------------------------------------------------
    logic [7:0] raw_fail;
    logic [7:0] fail_d;

    // Raw check results, before valid qualification and masking.
    always_comb begin
        raw_fail    = '0;
        raw_fail[0] = pstatus[0] && (e_z != E_ZERO);
        raw_fail[1] = pstatus[1] && (e_z != E_ONES);
        raw_fail[2] = pstatus[2] &&
                      !(((e_a == E_ZERO) && (e_b == E_ONES)) ||
                        ((e_a == E_ONES) && (e_b == E_ZERO)));
        raw_fail[3] = pstatus[3] && !((e_z == E_ZERO) || (pz[W-2:0] == MINN));
        raw_fail[4] = pstatus[4] && !((e_z == E_ONES) || (pz[W-2:0] == MAXN));
        raw_fail[5] = (pstatus[0] && pstatus[1]) || (pstatus[2] && pstatus[0]);
        raw_fail[6] = |pstatus[7:6];
        // Protocol: result valid must track the retimed operand valid every cycle.
        raw_fail[7] = (out_valid != dv);
    end

    // Status checks only count on valid results; the protocol check always counts.
    always_comb begin
        fail_d      = '0;
        fail_d[6:0] = out_valid ? (raw_fail[6:0] & chk_mask[6:0]) : 7'd0;
        fail_d[7]   = raw_fail[7] & chk_mask[7];
    end

    // Lowest-numbered failing check, for the first-failure record.
    logic [2:0] low_idx;
    always_comb begin
        low_idx = '0;
        for (int k = 7; k >= 0; k--) begin
            if (fail_d[k]) begin
                low_idx = 3'(k);
            end
        end
    end

    // ------------------------------------------------------------------
    // Bookkeeping state
    // ------------------------------------------------------------------
    logic [7:0]       fail_pulse_q;
    logic             irq_q;
    logic [7:0]       sticky_q,      sticky_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic             first_valid_q, first_valid_d;
    logic [2:0]       first_id_q,    first_id_d;
    logic [31:0]      first_time_q,  first_time_d;
    logic [31:0]      cyc_q,         cyc_d;

    // Sticky flags: clear wins over failures arriving in the same cycle.
    always_comb begin
        sticky_d = clear ? 8'd0 : (sticky_q | fail_d);
    end

    // Saturating per-check counters; clear wins over a simultaneous increment.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clear) begin
                cnt_d[k] = '0;
            end else if (fail_d[k] && (cnt_q[k] != CNT_MAX)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    // First-failure capture: latched once, only reopened by clear.
    always_comb begin
        first_valid_d = first_valid_q;
        first_id_d    = first_id_q;
        first_time_d  = first_time_q;
        if (clear) begin
            first_valid_d = 1'b0;
            first_id_d    = '0;
            first_time_d  = '0;
        end else if (!first_valid_q && (|fail_d)) begin
            first_valid_d = 1'b1;
            first_id_d    = low_idx;
            first_time_d  = cyc_q;
        end
    end

    // Free-running timestamp; wraps naturally and ignores clear.
    always_comb begin
        cyc_d = cyc_q + 32'd1;
    end

    // All bookkeeping registers; fail_pulse/irq report even when clear is active.
    always_ff @(posedge pclk) begin
        if (prst_n) begin
            fail_pulse_q  <= '0;
            irq_q         <= 1'b0;
            sticky_q      <= '0;
            first_valid_q <= 1'b0;
            first_id_q    <= '0;
            first_time_q  <= '0;
            cyc_q         <= '0;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            fail_pulse_q  <= fail_d;
            irq_q         <= |fail_d;
            sticky_q      <= sticky_d;
            first_valid_q <= first_valid_d;
            first_id_q    <= first_id_d;
            first_time_q  <= first_time_d;
            cyc_q         <= cyc_d;
            for (int k = 0; k < 8; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fail_pulse  = fail_pulse_q;
    assign irq         = irq_q;
    assign sticky      = sticky_q;
    assign first_valid = first_valid_q;
    assign first_id    = first_id_q;
    assign first_time  = first_time_q;

    for (genvar g = 0; g < 8; g++) begin : g_cnt_out
        assign fail_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_fp_mul_status_monitor.sv
module tb_fp_mul_status_monitor;

    localparam int EXP_W   = 8;
    localparam int MAN_W   = 23;
    localparam int LATENCY = 2;
    localparam int CNT_W   = 16;
    localparam int W       = 1 + EXP_W + MAN_W;
    localparam logic [W-1:0] ONE = 32'h3F80_0000;

    logic               pclk;
    logic               prst_n;
    logic               in_valid;
    logic [W-1:0]       pa;
    logic [W-1:0]       pb;
    logic               out_valid;
    logic [W-1:0]       pz;
    logic [7:0]         pstatus;
    logic               clear;
    logic [7:0]         chk_mask;
    logic [7:0]         fail_pulse;
    logic [7:0]         sticky;
    logic [8*CNT_W-1:0] fail_cnt;
    logic               first_valid;
    logic [2:0]         first_id;
    logic [31:0]        first_time;
    logic               irq;

    fp_mul_status_monitor #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .LATENCY(LATENCY), .CNT_W(CNT_W)
    ) dut (
        .pclk(pclk), .prst_n(prst_n), .in_valid(in_valid), .pa(pa), .pb(pb),
        .out_valid(out_valid), .pz(pz), .pstatus(pstatus), .clear(clear),
        .chk_mask(chk_mask), .fail_pulse(fail_pulse), .sticky(sticky),
        .fail_cnt(fail_cnt), .first_valid(first_valid), .first_id(first_id),
        .first_time(first_time), .irq(irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned cyc_model = 0;   // expected value of the DUT cycle counter
    int unsigned eval_cyc  = 0;   // counter value at the most recent edge
    int unsigned fe;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        eval_cyc = cyc_model;
        @(posedge pclk);
        if (prst_n) cyc_model = 0;
        else        cyc_model = cyc_model + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        prst_n = 1'b1; in_valid = 1'b0; out_valid = 1'b0;
        pa = ONE; pb = ONE; pz = '0; pstatus = 8'h00; clear = 1'b0; chk_mask = 8'hFF;
        tick(); tick();
        chk("rst_pulse", fail_pulse, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_cnt_lo", fail_cnt[63:0], 0);
        chk("rst_cnt_hi", fail_cnt[127:64], 0);
        chk("rst_fvalid", first_valid, 0);
        chk("rst_fid", first_id, 0);
        chk("rst_ftime", first_time, 0);
        chk("rst_irq", irq, 0);

        // Start a continuous, protocol-correct stream with passing status.
        prst_n = 1'b0; in_valid = 1'b1;
        tick(); tick();
        out_valid = 1'b1;
        tick();
        chk("stream_clean", fail_pulse, 8'h00);

        // C0 zero
        pz = 32'h0000_0000; pstatus = 8'h01; tick();
        chk("c0_pass", fail_pulse, 8'h00);
        pz = ONE; tick(); fe = eval_cyc;
        chk("c0_fail_pulse", fail_pulse, 8'h01);
        chk("c0_irq", irq, 1);
        chk("c0_cnt", fail_cnt[0*CNT_W +: CNT_W], 1);
        chk("c0_fvalid", first_valid, 1);
        chk("c0_fid", first_id, 0);
        chk("c0_ftime", first_time, fe);
        pstatus = 8'h00; tick();
        chk("c0_irq_drop", irq, 0);
        chk("c0_pulse_drop", fail_pulse, 8'h00);
        chk("c0_sticky", sticky, 8'h01);
        chk("c0_ftime_hold", first_time, fe);

        // C2 nan uses operands retimed by LATENCY
        pa = 32'h0000_0001; pb = 32'h7F80_0000; tick();
        pa = ONE; pb = ONE; tick();
        pstatus = 8'h04; tick();
        chk("c2_pass", fail_pulse, 8'h00);
        pstatus = 8'h00; pa = 32'h0000_0001; pb = ONE; tick();
        pa = ONE; tick();
        pstatus = 8'h04; tick();
        chk("c2_fail", fail_pulse, 8'h04);
        chk("c2_cnt", fail_cnt[2*CNT_W +: CNT_W], 1);

        // C4 huge / C3 tiny boundaries
        pstatus = 8'h10; pz = 32'h7F7F_FFFF; tick();
        chk("c4_maxn_pass", fail_pulse, 8'h00);
        pz = ONE; tick();
        chk("c4_fail", fail_pulse, 8'h10);
        pstatus = 8'h08; pz = 32'h0080_0000; tick();
        chk("c3_minn_pass", fail_pulse, 8'h00);
        pz = 32'h0080_0001; tick();
        chk("c3_fail", fail_pulse, 8'h08);

        // clear, then C6 becomes the first failure
        pstatus = 8'h00; clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_sticky", sticky, 8'h00);
        chk("clr_fvalid", first_valid, 0);
        chk("clr_cnt_lo", fail_cnt[63:0], 0);
        pstatus = 8'h40; tick();
        chk("c6_fail", fail_pulse, 8'h40);
        chk("c6_fid", first_id, 6);

        // C5 together with C0; lowest index captured
        pstatus = 8'h00; clear = 1'b1; tick(); clear = 1'b0;
        pstatus = 8'h03; pz = 32'h7F80_0000; tick();
        chk("c5_c0_fail", fail_pulse, 8'h21);
        chk("c5_fid", first_id, 0);
        chk("c5_sticky", sticky, 8'h21);

        // Mask change applies in the same cycle
        pstatus = 8'h01; pz = ONE; chk_mask = 8'hFE; tick();
        chk("mask_off", fail_pulse, 8'h00);
        chk_mask = 8'hFF; pstatus = 8'h00;

        // Drain the stream cleanly, then a protocol violation
        in_valid = 1'b0; tick(); tick();
        out_valid = 1'b0; tick();
        chk("drain_clean", fail_pulse, 8'h00);
        clear = 1'b1; tick(); clear = 1'b0;
        in_valid = 1'b1; tick();
        in_valid = 1'b0; out_valid = 1'b1; tick();
        chk("c7_early", fail_pulse, 8'h80);
        out_valid = 1'b0; tick();
        chk("c7_missing", fail_pulse, 8'h80);
        tick();
        chk("c7_quiet", fail_pulse, 8'h00);
        chk("c7_cnt", fail_cnt[7*CNT_W +: CNT_W], 2);

        // Counter saturation on C1
        chk_mask = 8'h02; out_valid = 1'b1; pstatus = 8'h02; pz = '0;
        repeat (65534) tick();
        chk("sat_minus1", fail_cnt[1*CNT_W +: CNT_W], 16'hFFFE);
        tick();
        chk("sat_max", fail_cnt[1*CNT_W +: CNT_W], 16'hFFFF);
        repeat (70000 - 65535) tick();
        chk("sat_hold", fail_cnt[1*CNT_W +: CNT_W], 16'hFFFF);
        chk("sat_sticky", sticky, 8'h82);
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clr_pri_pulse", fail_pulse, 8'h02);
        chk("clr_pri_cnt", fail_cnt[1*CNT_W +: CNT_W], 0);
        chk("clr_pri_sticky", sticky, 8'h00);
        chk("clr_pri_irq", irq, 1);
        chk("clr_pri_fvalid", first_valid, 0);

        // Reset with operands in flight
        chk_mask = 8'hFF; out_valid = 1'b0; pstatus = 8'h00; in_valid = 1'b1;
        tick();
        out_valid = 1'b1; pstatus = 8'h40; tick();
        chk("pre_rst_fail", fail_pulse, 8'hC0);
        prst_n = 1'b1; in_valid = 1'b0; out_valid = 1'b0; pstatus = 8'h00; tick();
        chk("mrst_pulse", fail_pulse, 0);
        chk("mrst_sticky", sticky, 0);
        chk("mrst_cnt_lo", fail_cnt[63:0], 0);
        chk("mrst_cnt_hi", fail_cnt[127:64], 0);
        chk("mrst_fvalid", first_valid, 0);
        chk("mrst_ftime", first_time, 0);
        chk("mrst_irq", irq, 0);
        prst_n = 1'b0; out_valid = 1'b1; tick();
        chk("post_rst_c7", fail_pulse, 8'h80);
        chk("post_rst_fid", first_id, 7);
        chk("post_rst_ftime", first_time, eval_cyc);
        chk("post_rst_ftime0", first_time, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
